// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues word reads over a
// req/ack handshake and buffers returned words in a 2-entry queue for decode.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] inst
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        count_q, count_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   pc0_q, pc0_d, inst0_q, inst0_d;
  logic [XLEN-1:0]   pc1_q, pc1_d, inst1_q, inst1_d;

  logic              pending;
  logic              pop;
  logic              push;
  logic [1:0]        cnt_after;
  logic [1:0]        wr_idx;
  logic [XLEN-1:0]   target;
  logic [XLEN-1:0]   rpc;

  // Next-state: request handshake, redirect flush and queue push/pop
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    pc0_d      = pc0_q;
    inst0_d    = inst0_q;
    pc1_d      = pc1_q;
    inst1_d    = inst1_q;
    push       = 1'b0;
    cnt_after  = count_q;
    target     = fetch_pc_q;
    wr_idx     = 2'd0;

    pending = (state_q != IDLE);
    pop     = (count_q != 2'd0) && !stall && !redirect;
    rpc     = redirect_pc & ~32'h0000_0003;

    if (pending && !imem_ack) begin
      // Request outstanding: it must be held; a redirect only marks it stale
      if (redirect) begin
        count_d    = 2'd0;
        fetch_pc_d = rpc;
        if (state_q == FETCH) state_d = DROP;
      end else begin
        count_d = count_q - 2'(pop);
      end
    end else begin
      push = (state_q == FETCH) && imem_ack && !redirect;
      if (redirect) begin
        cnt_after = 2'd0;
        target    = rpc;
      end else begin
        cnt_after = count_q - 2'(pop) + 2'(push);
        target    = fetch_pc_q;
      end
      count_d = cnt_after;
      if (cnt_after < 2'd2) begin
        addr_d     = target;
        fetch_pc_d = target + 32'd4;
        state_d    = FETCH;
      end else begin
        state_d = IDLE;
      end
    end

    // Shift queue: head always in slot 0; emptied head keeps its last value
    if (pop && (count_q == 2'd2)) begin
      pc0_d   = pc1_q;
      inst0_d = inst1_q;
    end
    if (push) begin
      wr_idx = count_q - 2'(pop);
      if (wr_idx == 2'd0) begin
        pc0_d   = addr_q;
        inst0_d = imem_rdata;
      end else begin
        pc1_d   = addr_q;
        inst1_d = imem_rdata;
      end
    end
  end

  // State and queue registers with asynchronous clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= 2'd0;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      pc0_q      <= RESET_PC;
      inst0_q    <= NOP;
      pc1_q      <= RESET_PC;
      inst1_q    <= NOP;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      pc0_q      <= pc0_d;
      inst0_q    <= inst0_d;
      pc1_q      <= pc1_d;
      inst1_q    <= inst1_d;
    end
  end

  assign imem_req   = (state_q != IDLE);
  assign imem_addr  = addr_q;
  assign inst_valid = (count_q != 2'd0);
  assign pc         = pc0_q;
  assign inst       = inst0_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a wait-state-programmable memory model.
module tb_inst_fetch;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] inst;

  int unsigned wait_n;
  int unsigned wcnt;
  int          n_assert = 0;
  int          n_fail   = 0;

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clock       (clock),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .pc          (pc),
    .inst        (inst)
  );

  always #5 clock = ~clock;

  // Memory model: acks after wait_n wait cycles, data = addr ^ KEY
  always @(posedge clock) begin
    if (!imem_req || imem_ack) wcnt <= 0;
    else                       wcnt <= wcnt + 1;
  end
  assign imem_ack   = imem_req && (wcnt == wait_n);
  assign imem_rdata = imem_addr ^ KEY;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] exp_pc);
    chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
    chk({tag, "_pc"}, pc, exp_pc);
    chk({tag, "_inst"}, inst, exp_pc ^ KEY);
  endtask

  initial begin
    wcnt        = 0;
    wait_n      = 0;
    reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    #3;
    chk("rst_req",   {31'd0, imem_req},   32'd0);
    chk("rst_addr",  imem_addr,           32'h0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_pc",    pc,                  32'h0);
    chk("rst_inst",  inst,                32'h0000_0013);

    // Release reset: cycle 0 idle, cycle 1 request, cycle 2 first word
    step();
    reset = 1'b0;
    chk("c0_req", {31'd0, imem_req}, 32'd0);
    step();
    chk("c1_req",  {31'd0, imem_req}, 32'd1);
    chk("c1_addr", imem_addr, 32'h0);
    chk("c1_valid", {31'd0, inst_valid}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_head("stream", 32'(4 * k));
    end

    // Stall with pc=8 at head: queue fills with 8,12 and requests stop
    stall = 1'b1;
    chk("s1_addr", imem_addr, 32'hC);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_head("stall_hold", 32'h8);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
    end
    stall = 1'b0;
    step();
    chk_head("rel_12", 32'hC);
    chk("rel_req", {31'd0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr, 32'h10);
    step();
    chk_head("rel_16", 32'h10);
    step();
    chk_head("rel_20", 32'h14);

    // Redirect with zero-wait memory, unaligned target
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    chk("rd1_req",   {31'd0, imem_req},   32'd1);
    chk("rd1_addr",  imem_addr,           32'h100);
    chk("rd1_valid", {31'd0, inst_valid}, 32'd0);
    step();
    chk_head("rd2", 32'h100);
    step();
    chk_head("rd3", 32'h104);

    // Three wait states; redirect in the second wait cycle of fetch 0x108
    wait_n = 3;
    chk("wA_addr", imem_addr, 32'h108);
    step();
    chk("wB_valid", {31'd0, inst_valid}, 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    step();
    redirect = 1'b0;
    chk("wC_addr", imem_addr, 32'h108);
    chk("wC_req", {31'd0, imem_req}, 32'd1);
    step();
    chk("wD_addr", imem_addr, 32'h108);
    chk("wD_valid", {31'd0, inst_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("wE_addr", imem_addr, 32'h200);
      chk("wE_valid", {31'd0, inst_valid}, 32'd0);
    end
    step();
    chk_head("wI", 32'h200);
    chk("wI_addr", imem_addr, 32'h204);
    wait_n = 0;
    step();
    chk_head("wJ", 32'h204);

    // Redirect near the top of the address space: PC wraps to zero
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFF8);
    step();
    chk_head("wrap_f8", 32'hFFFF_FFF8);
    step();
    chk_head("wrap_fc", 32'hFFFF_FFFC);
    step();
    chk_head("wrap_00", 32'h0);

    // Asynchronous reset while a request is pending
    wait_n = 3;
    chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_req",   {31'd0, imem_req},   32'd0);
    chk("arst_valid", {31'd0, inst_valid}, 32'd0);
    wait_n = 0;
    step();
    reset = 1'b0;
    chk("r0_req", {31'd0, imem_req}, 32'd0);
    step();
    chk("r1_req",  {31'd0, imem_req}, 32'd1);
    chk("r1_addr", imem_addr, 32'h0);
    step();
    chk_head("r2", 32'h0);
    step();
    chk_head("r3", 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
